// File: rtl/instr_pkg.sv
// Shared opcode, IR nibble, FIFO entry and issue-state definitions for the encoder and decoder.
// Pure declarations: no logic, no latency, no backpressure.
package instr_pkg;
    localparam logic [3:0] OP_MOVA = 4'd0;
    localparam logic [3:0] OP_MOVB = 4'd1;
    localparam logic [3:0] OP_MOVC = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_RSR  = 4'd7;
    localparam logic [3:0] OP_RSL  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_JZ   = 4'd10;
    localparam logic [3:0] OP_JC   = 4'd11;
    localparam logic [3:0] OP_IN   = 4'd12;
    localparam logic [3:0] OP_OUT  = 4'd13;
    localparam logic [3:0] OP_NOP  = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [3:0] NIB_MOV  = 4'b1100;
    localparam logic [3:0] NIB_ADD  = 4'b1001;
    localparam logic [3:0] NIB_SUB  = 4'b0110;
    localparam logic [3:0] NIB_AND  = 4'b1011;
    localparam logic [3:0] NIB_NOT  = 4'b0101;
    localparam logic [3:0] NIB_SHF  = 4'b1010;
    localparam logic [3:0] NIB_JMP  = 4'b0011;
    localparam logic [3:0] NIB_IN   = 4'b0010;
    localparam logic [3:0] NIB_OUT  = 4'b0100;
    localparam logic [3:0] NIB_NOP  = 4'b0111;
    localparam logic [3:0] NIB_HALT = 4'b1000;

    localparam logic [7:0] IR_HALT = {NIB_HALT, 4'b0000};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_ADDR = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] ir;
        logic [7:0] addr;
        logic       has_addr;
    } entry_t;
endpackage

// File: rtl/instr_fifo.sv
// DEPTH-entry synchronous FIFO of encoded IR entries; writes visible at head one cycle after push.
// No internal backpressure: the caller must not push when full_o or pop when empty_o.
module instr_fifo
    import instr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  entry_t      push_dat_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        empty_o,
    output logic        multi_o,
    output entry_t      head_o,
    output logic [7:0]  second_ir_o
);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_TWO  = (AW+1)'(2);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push_i && !pop_i)      count_q <= count_q + CNT_ONE;
            else if (pop_i && !push_i) count_q <= count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    // Second entry lets the issuer chain into the next opcode without a bubble.
    assign head_o      = mem_q[rd_ptr_q];
    assign second_ir_o = mem_q[rd_ptr_q + PTR_ONE].ir;
    assign full_o      = (count_q == CNT_FULL);
    assign empty_o     = (count_q == '0);
    assign multi_o     = (count_q >= CNT_TWO);
endmodule

// File: rtl/instr_encoder.sv
// Encodes mnemonic requests into IR bytes, queues them, and issues opcode (+address) bytes on ir/en.
// Opcode appears 2 cycles after accept; req_ready drops when the queue is full; issue freezes after HALT.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_rs,
    input  logic [7:0]  req_addr,
    output logic        req_err,
    output logic [7:0]  ir,
    output logic        en,
    input  logic        ir_ready,
    output logic        halted,
    input  logic        resume
);
    entry_t      enc_d;
    logic        illegal_d;
    entry_t      head;
    logic [7:0]  second_ir;
    logic        full, empty, multi;
    logic        accept, push, pop, has_next;
    logic [7:0]  next_ir;

    state_t      state_q;
    logic [7:0]  ir_q;
    logic        en_q, halted_q, req_err_q;

    always_comb begin
        enc_d     = '0;
        illegal_d = 1'b0;
        case (req_op)
            OP_MOVA: begin
                enc_d.ir  = {NIB_MOV, req_rd, req_rs};
                illegal_d = (req_rd == 2'd3) || (req_rs == 2'd3);
            end
            OP_MOVB: begin
                enc_d.ir  = {NIB_MOV, 2'b11, req_rs};
                illegal_d = (req_rs == 2'd3);
            end
            OP_MOVC: begin
                enc_d.ir  = {NIB_MOV, req_rd, 2'b11};
                illegal_d = (req_rd == 2'd3);
            end
            OP_ADD:  enc_d.ir = {NIB_ADD, req_rd, req_rs};
            OP_SUB:  enc_d.ir = {NIB_SUB, req_rd, req_rs};
            OP_AND:  enc_d.ir = {NIB_AND, req_rd, req_rs};
            OP_NOT:  enc_d.ir = {NIB_NOT, req_rd, 2'b00};
            OP_RSR:  enc_d.ir = {NIB_SHF, req_rd, 2'b00};
            OP_RSL:  enc_d.ir = {NIB_SHF, req_rd, 2'b11};
            OP_JMP, OP_JZ, OP_JC: begin
                enc_d.ir       = {NIB_JMP, 2'b00, req_op[1:0] - 2'd1};
                enc_d.addr     = req_addr;
                enc_d.has_addr = 1'b1;
            end
            OP_IN:   enc_d.ir = {NIB_IN,  req_rd, 2'b00};
            OP_OUT:  enc_d.ir = {NIB_OUT, req_rd, 2'b00};
            OP_NOP:  enc_d.ir = {NIB_NOP, 4'b0000};
            default: enc_d.ir = IR_HALT;
        endcase
    end

    assign req_ready = !full;
    assign accept    = req_valid && req_ready;
    assign push      = accept && !illegal_d;
    assign pop       = ir_ready && ((state_q == ST_ADDR) || (state_q == ST_OP && !head.has_addr));
    // A push landing on the last remaining entry is forwarded so the chain stays unbroken.
    assign has_next  = multi || push;
    assign next_ir   = multi ? second_ir : enc_d.ir;

    instr_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_dat_i  (enc_d),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .multi_o     (multi),
        .head_o      (head),
        .second_ir_o (second_ir)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ir_q      <= 8'h00;
            en_q      <= 1'b0;
            halted_q  <= 1'b0;
            req_err_q <= 1'b0;
        end else begin
            req_err_q <= accept && illegal_d;
            if (resume && halted_q) halted_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!empty && !halted_q) begin
                        state_q <= ST_OP;
                        ir_q    <= head.ir;
                        en_q    <= 1'b1;
                    end
                end
                ST_OP, ST_ADDR: begin
                    if (ir_ready) begin
                        if (state_q == ST_OP && head.has_addr) begin
                            state_q <= ST_ADDR;
                            ir_q    <= head.addr;
                        end else if (state_q == ST_OP && head.ir == IR_HALT) begin
                            // Set wins over a coincident resume pulse.
                            halted_q <= 1'b1;
                            state_q  <= ST_IDLE;
                            ir_q     <= 8'h00;
                            en_q     <= 1'b0;
                        end else if (has_next) begin
                            state_q <= ST_OP;
                            ir_q    <= next_ir;
                        end else begin
                            state_q <= ST_IDLE;
                            ir_q    <= 8'h00;
                            en_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ir_q    <= 8'h00;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ir      = ir_q;
    assign en      = en_q;
    assign halted  = halted_q;
    assign req_err = req_err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding, latency, stalls, back-to-back issue, HALT/resume, reset.
module tb_instr_encoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_op = 4'd0;
    logic [1:0] req_rd = 2'd0;
    logic [1:0] req_rs = 2'd0;
    logic [7:0] req_addr = 8'h00;
    logic       req_err;
    logic [7:0] ir;
    logic       en;
    logic       ir_ready = 1'b0;
    logic       halted;
    logic       resume = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rd    (req_rd),
        .req_rs    (req_rs),
        .req_addr  (req_addr),
        .req_err   (req_err),
        .ir        (ir),
        .en        (en),
        .ir_ready  (ir_ready),
        .halted    (halted),
        .resume    (resume)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [7:0] addr);
        req_valid = 1'b1;
        req_op    = op;
        req_rd    = rd;
        req_rs    = rs;
        req_addr  = addr;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if ({en, ir} !== 9'h000) begin errors++; $display("FAIL reset_ir_en: got en=%b ir=%h exp en=0 ir=00", en, ir); end
        checks++; if (req_err !== 1'b0) begin errors++; $display("FAIL reset_req_err: got %b exp 0", req_err); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b exp 0", halted); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b exp 1", req_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add;
        ir_ready = 1'b1;
        send(4'd3, 2'd1, 2'd2, 8'h00);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b exp 1", req_ready); end
        tick();
        req_valid = 1'b0;
        checks++; if ({en, ir} !== 9'h000) begin errors++; $display("FAIL add_n1: got en=%b ir=%h exp en=0 ir=00", en, ir); end
        checks++; if (req_err !== 1'b0) begin errors++; $display("FAIL add_err: got %b exp 0", req_err); end
        tick();
        checks++; if ({en, ir} !== 9'h196) begin errors++; $display("FAIL add_issue: got en=%b ir=%h exp en=1 ir=96", en, ir); end
        tick();
        checks++; if ({en, ir} !== 9'h000) begin errors++; $display("FAIL add_done: got en=%b ir=%h exp en=0 ir=00", en, ir); end
    endtask

    task automatic test_jz_stall;
        ir_ready = 1'b0;
        send(4'd10, 2'd0, 2'd0, 8'h3C);
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if ({en, ir} !== 9'h131) begin errors++; $display("FAIL jz_hold[%0d]: got en=%b ir=%h exp en=1 ir=31", i, en, ir); end
            if (i == 3) ir_ready = 1'b1;
            tick();
        end
        checks++; if ({en, ir} !== 9'h13C) begin errors++; $display("FAIL jz_addr: got en=%b ir=%h exp en=1 ir=3c", en, ir); end
        tick();
        checks++; if ({en, ir} !== 9'h000) begin errors++; $display("FAIL jz_done: got en=%b ir=%h exp en=0 ir=00", en, ir); end
    endtask

    task automatic test_illegal;
        ir_ready = 1'b1;
        send(4'd0, 2'd3, 2'd0, 8'h00);
        tick();
        req_valid = 1'b0;
        checks++; if (req_err !== 1'b1) begin errors++; $display("FAIL illegal_err_pulse: got %b exp 1", req_err); end
        tick();
        checks++; if (req_err !== 1'b0) begin errors++; $display("FAIL illegal_err_clear: got %b exp 0", req_err); end
        tick();
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL illegal_no_issue: got en=%b exp 0", en); end
        send(4'd2, 2'd2, 2'd0, 8'h00);
        tick();
        req_valid = 1'b0;
        checks++; if (req_err !== 1'b0) begin errors++; $display("FAIL movc_err: got %b exp 0", req_err); end
        tick();
        checks++; if ({en, ir} !== 9'h1CB) begin errors++; $display("FAIL movc_issue: got en=%b ir=%h exp en=1 ir=cb", en, ir); end
        tick();
    endtask

    task automatic test_encodings;
        logic [3:0] ops [8] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12, 4'd1, 4'd11};
        logic [1:0] rds [8] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd3, 2'd0, 2'd0};
        logic [1:0] rss [8] = '{2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0};
        logic [7:0] exp [8] = '{8'h67, 8'hB9, 8'h5C, 8'hA8, 8'hA7, 8'h2C, 8'hCE, 8'h32};
        ir_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(ops[i], rds[i], rss[i], 8'hA5);
            tick();
            req_valid = 1'b0;
            tick();
            checks++; if ({en, ir} !== {1'b1, exp[i]}) begin errors++; $display("FAIL enc[%0d]: got en=%b ir=%h exp en=1 ir=%h", i, en, ir, exp[i]); end
            tick();
            if (ops[i] == 4'd11) begin
                checks++; if ({en, ir} !== 9'h1A5) begin errors++; $display("FAIL enc_jc_addr: got en=%b ir=%h exp en=1 ir=a5", en, ir); end
                tick();
            end
        end
    endtask

    task automatic test_back_to_back;
        ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(4'd14, 2'd0, 2'd0, 8'h00);
            checks++; if (req_ready !== (i < 4)) begin errors++; $display("FAIL fill_ready[%0d]: got %b exp %b", i, req_ready, (i < 4)); end
            tick();
        end
        req_valid = 1'b0;
        ir_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({en, ir} !== 9'h170) begin errors++; $display("FAIL b2b[%0d]: got en=%b ir=%h exp en=1 ir=70", i, en, ir); end
            tick();
        end
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL b2b_done: got en=%b exp 0", en); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", req_ready); end
    endtask

    task automatic test_halt;
        ir_ready = 1'b1;
        send(4'd15, 2'd0, 2'd0, 8'h00);
        tick();
        send(4'd13, 2'd1, 2'd0, 8'h00);
        tick();
        req_valid = 1'b0;
        checks++; if ({en, ir} !== 9'h180) begin errors++; $display("FAIL halt_issue: got en=%b ir=%h exp en=1 ir=80", en, ir); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({halted, en} !== 2'b10) begin errors++; $display("FAIL halt_frozen[%0d]: got halted=%b en=%b exp halted=1 en=0", i, halted, en); end
            tick();
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        checks++; if ({halted, en} !== 2'b00) begin errors++; $display("FAIL resume_clear: got halted=%b en=%b exp halted=0 en=0", halted, en); end
        tick();
        checks++; if ({en, ir} !== 9'h144) begin errors++; $display("FAIL resume_issue: got en=%b ir=%h exp en=1 ir=44", en, ir); end
        tick();
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL resume_done: got en=%b exp 0", en); end
    endtask

    task automatic test_reset_addr;
        ir_ready = 1'b1;
        send(4'd9, 2'd0, 2'd0, 8'h55);
        tick();
        send(4'd14, 2'd0, 2'd0, 8'h00);
        tick();
        req_valid = 1'b0;
        checks++; if ({en, ir} !== 9'h130) begin errors++; $display("FAIL jmp_op: got en=%b ir=%h exp en=1 ir=30", en, ir); end
        tick();
        checks++; if ({en, ir} !== 9'h155) begin errors++; $display("FAIL jmp_addr: got en=%b ir=%h exp en=1 ir=55", en, ir); end
        ir_ready = 1'b0;
        rst_n    = 1'b0;
        tick();
        checks++; if ({en, ir} !== 9'h000) begin errors++; $display("FAIL rst_mid_en: got en=%b ir=%h exp en=0 ir=00", en, ir); end
        checks++; if ({halted, req_ready} !== 2'b01) begin errors++; $display("FAIL rst_mid_state: got halted=%b req_ready=%b exp halted=0 req_ready=1", halted, req_ready); end
        rst_n    = 1'b1;
        ir_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (en !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet[%0d]: got en=%b ir=%h exp en=0", i, en, ir); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_jz_stall();
        test_illegal();
        test_encodings();
        test_back_to_back();
        test_halt();
        test_reset_addr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
